// File: rtl/ddr_ring_sequencer_if.sv
// DataMover command/status bundle for both directions.
// master = sequencer side, slave = DataMover side.
interface ddr_ring_sequencer_if;
    // S2MM direction
    logic        m_axis_s2mm_cmdsts_aresetn;
    logic [71:0] S_AXIS_S2MM_CMD_tdata;
    logic        S_AXIS_S2MM_CMD_tvalid;
    logic        S_AXIS_S2MM_CMD_tready;
    logic [7:0]  M_AXIS_S2MM_STS_tdata;
    logic        M_AXIS_S2MM_STS_tvalid;
    logic        M_AXIS_S2MM_STS_tready;
    // MM2S direction
    logic        m_axis_mm2s_cmdsts_aresetn;
    logic [71:0] S_AXIS_MM2S_CMD_tdata;
    logic        S_AXIS_MM2S_CMD_tvalid;
    logic        S_AXIS_MM2S_CMD_tready;
    logic [7:0]  M_AXIS_MM2S_STS_tdata;
    logic        M_AXIS_MM2S_STS_tvalid;
    logic        M_AXIS_MM2S_STS_tready;

    modport master (
        output m_axis_s2mm_cmdsts_aresetn, S_AXIS_S2MM_CMD_tdata, S_AXIS_S2MM_CMD_tvalid,
               M_AXIS_S2MM_STS_tready,
               m_axis_mm2s_cmdsts_aresetn, S_AXIS_MM2S_CMD_tdata, S_AXIS_MM2S_CMD_tvalid,
               M_AXIS_MM2S_STS_tready,
        input  S_AXIS_S2MM_CMD_tready, M_AXIS_S2MM_STS_tdata, M_AXIS_S2MM_STS_tvalid,
               S_AXIS_MM2S_CMD_tready, M_AXIS_MM2S_STS_tdata, M_AXIS_MM2S_STS_tvalid
    );

    modport slave (
        input  m_axis_s2mm_cmdsts_aresetn, S_AXIS_S2MM_CMD_tdata, S_AXIS_S2MM_CMD_tvalid,
               M_AXIS_S2MM_STS_tready,
               m_axis_mm2s_cmdsts_aresetn, S_AXIS_MM2S_CMD_tdata, S_AXIS_MM2S_CMD_tvalid,
               M_AXIS_MM2S_STS_tready,
        output S_AXIS_S2MM_CMD_tready, M_AXIS_S2MM_STS_tdata, M_AXIS_S2MM_STS_tvalid,
               S_AXIS_MM2S_CMD_tready, M_AXIS_MM2S_STS_tdata, M_AXIS_MM2S_STS_tvalid
    );
endinterface

// File: rtl/ddr_ring_sequencer.sv
// Capture/readback sequencer for the AXI DataMover: NUM_BLOCKS S2MM commands
// over the ring region, then NUM_BLOCKS MM2S commands over the same region,
// one command outstanding at a time, each status beat checked before moving on.
// A bad status pulses the failing direction's cmdsts reset and parks in ERROR.
module ddr_ring_sequencer #(
    parameter logic [22:0] BTT        = 23'h00_1000,
    parameter int          NUM_BLOCKS = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [3:0]  S2MM_TAG   = 4'hA,
    parameter logic [3:0]  MM2S_TAG   = 4'h5,
    parameter int          RST_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] err_status,
    ddr_ring_sequencer_if.master dm
);

    typedef enum logic [2:0] {
        IDLE, S2MM_CMD, S2MM_STS, MM2S_CMD, MM2S_STS, DONE, RECOVER, ERROR
    } state_t;

    localparam int             RCW     = $clog2(RST_CYCLES);
    localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [7:0]     K_LAST  = 8'(NUM_BLOCKS - 1);
    localparam logic [31:0]    BTT_EXT = {9'b0, BTT};

    state_t         state_q, state_d;
    logic [7:0]     k_q, k_d;
    logic [31:0]    addr_q, addr_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [7:0]     err_status_q, err_status_d;
    logic           fail_mm2s_q, fail_mm2s_d;
    logic           s2mm_rstn_q, s2mm_rstn_d;
    logic           mm2s_rstn_q, mm2s_rstn_d;

    // The status path is shared: whichever *_STS state we are in selects its beat and tag.
    logic       in_s2mm_sts;
    logic       sts_vld;
    logic [7:0] sts_data;
    logic [3:0] sts_tag;
    logic       sts_good;

    // State register; aresetn flops reset low and rise on the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= 8'd0;
            addr_q       <= BASE_ADDR;
            rcnt_q       <= '0;
            err_status_q <= 8'h00;
            fail_mm2s_q  <= 1'b0;
            s2mm_rstn_q  <= 1'b0;
            mm2s_rstn_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            addr_q       <= addr_d;
            rcnt_q       <= rcnt_d;
            err_status_q <= err_status_d;
            fail_mm2s_q  <= fail_mm2s_d;
            s2mm_rstn_q  <= s2mm_rstn_d;
            mm2s_rstn_q  <= mm2s_rstn_d;
        end
    end

    // Next state: block walk, status check, recovery timing.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        addr_d       = addr_q;
        rcnt_d       = rcnt_q;
        err_status_d = err_status_q;
        fail_mm2s_d  = fail_mm2s_q;

        in_s2mm_sts = (state_q == S2MM_STS);
        sts_vld     = in_s2mm_sts ? dm.M_AXIS_S2MM_STS_tvalid : dm.M_AXIS_MM2S_STS_tvalid;
        sts_data    = in_s2mm_sts ? dm.M_AXIS_S2MM_STS_tdata  : dm.M_AXIS_MM2S_STS_tdata;
        sts_tag     = in_s2mm_sts ? S2MM_TAG : MM2S_TAG;
        sts_good    = sts_data[7] && (sts_data[6:4] == 3'b000) && (sts_data[3:0] == sts_tag);

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = S2MM_CMD;
                    k_d          = 8'd0;
                    addr_d       = BASE_ADDR;
                    err_status_d = 8'h00;
                end
            end
            // tvalid is a pure function of state, so tready alone completes the handshake.
            S2MM_CMD: if (dm.S_AXIS_S2MM_CMD_tready) state_d = S2MM_STS;
            MM2S_CMD: if (dm.S_AXIS_MM2S_CMD_tready) state_d = MM2S_STS;
            S2MM_STS, MM2S_STS: begin
                if (sts_vld) begin
                    if (!sts_good) begin
                        err_status_d = sts_data;
                        fail_mm2s_d  = !in_s2mm_sts;
                        rcnt_d       = '0;
                        state_d      = RECOVER;
                    end else if (k_q == K_LAST) begin
                        k_d     = 8'd0;
                        addr_d  = BASE_ADDR;
                        state_d = in_s2mm_sts ? MM2S_CMD : DONE;
                    end else begin
                        k_d     = k_q + 8'd1;
                        addr_d  = addr_q + BTT_EXT;   // wraps modulo 2^32
                        state_d = in_s2mm_sts ? S2MM_CMD : MM2S_CMD;
                    end
                end
            end
            RECOVER: begin
                if (rcnt_q == RC_LAST) state_d = ERROR;
                else                   rcnt_d  = rcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Registered from the next state so the low pulse lines up exactly with RECOVER.
        s2mm_rstn_d = !((state_d == RECOVER) && !fail_mm2s_d);
        mm2s_rstn_d = !((state_d == RECOVER) &&  fail_mm2s_d);
    end

    // Outputs decoded from the registered state; tdata is zero whenever tvalid is low.
    always_comb begin
        busy       = (state_q == S2MM_CMD) || (state_q == S2MM_STS) ||
                     (state_q == MM2S_CMD) || (state_q == MM2S_STS) || (state_q == RECOVER);
        done       = (state_q == DONE);
        err        = (state_q == RECOVER) || (state_q == ERROR);
        err_status = err_status_q;

        dm.m_axis_s2mm_cmdsts_aresetn = s2mm_rstn_q;
        dm.m_axis_mm2s_cmdsts_aresetn = mm2s_rstn_q;

        dm.S_AXIS_S2MM_CMD_tvalid = (state_q == S2MM_CMD);
        dm.S_AXIS_MM2S_CMD_tvalid = (state_q == MM2S_CMD);
        dm.S_AXIS_S2MM_CMD_tdata  = (state_q == S2MM_CMD) ?
                                    {4'h0, S2MM_TAG, addr_q, 8'h00, 1'b1, BTT} : 72'h0;
        dm.S_AXIS_MM2S_CMD_tdata  = (state_q == MM2S_CMD) ?
                                    {4'h0, MM2S_TAG, addr_q, 8'h00, 1'b1, BTT} : 72'h0;

        dm.M_AXIS_S2MM_STS_tready = (state_q == S2MM_STS);
        dm.M_AXIS_MM2S_STS_tready = (state_q == MM2S_STS);
    end

endmodule

// File: tb/tb_ddr_ring_sequencer.sv
// Bench for ddr_ring_sequencer: table of runs against a 2-block DUT with a
// scripted DataMover, a wrap-around DUT at the top of the address space, and
// hand sequences for reset behaviour.
module tb_ddr_ring_sequencer;

    localparam logic [22:0] BTT = 23'h1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start_a, busy_a, done_a, err_a;
    logic [7:0] err_status_a;
    logic       start_b, busy_b, done_b, err_b;
    logic [7:0] err_status_b;

    ddr_ring_sequencer_if ifa();
    ddr_ring_sequencer_if ifb();

    ddr_ring_sequencer #(.BTT(BTT), .NUM_BLOCKS(2), .BASE_ADDR(32'h0000_0000),
                         .S2MM_TAG(4'hA), .MM2S_TAG(4'h5), .RST_CYCLES(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .err(err_a), .err_status(err_status_a), .dm(ifa));

    ddr_ring_sequencer #(.BTT(BTT), .NUM_BLOCKS(2), .BASE_ADDR(32'hFFFF_F000),
                         .S2MM_TAG(4'hA), .MM2S_TAG(4'h5), .RST_CYCLES(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .err(err_b), .err_status(err_status_b), .dm(ifb));

    int tests = 0;
    int fails = 0;

    logic [71:0] exp_q[$];
    logic [71:0] first_cmd;

    typedef struct {
        int         hold;        // cycles first command's tready is held low
        bit         poke;        // pulse start while in MM2S_STS
        int         bad_beat;    // 0,1 = S2MM blocks, 2,3 = MM2S blocks, -1 = none
        logic [7:0] bad_val;
        bit         exp_done;
        bit         exp_err;
        logic [7:0] exp_err_status;
        bit         exp_fail_mm;
        int         exp_cmds;
    } vec_t;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] mk_cmd(input logic [3:0] tag, input logic [31:0] addr);
        return {4'h0, tag, addr, 8'h00, 1'b1, BTT};
    endfunction

    function automatic logic cmd_vld(input bit mm);
        return mm ? ifa.S_AXIS_MM2S_CMD_tvalid : ifa.S_AXIS_S2MM_CMD_tvalid;
    endfunction

    function automatic logic [71:0] cmd_dat(input bit mm);
        return mm ? ifa.S_AXIS_MM2S_CMD_tdata : ifa.S_AXIS_S2MM_CMD_tdata;
    endfunction

    function automatic logic sts_rdy(input bit mm);
        return mm ? ifa.M_AXIS_MM2S_STS_tready : ifa.M_AXIS_S2MM_STS_tready;
    endfunction

    task automatic set_cmd_rdy(input bit mm, input logic v);
        if (mm) ifa.S_AXIS_MM2S_CMD_tready = v;
        else    ifa.S_AXIS_S2MM_CMD_tready = v;
    endtask

    task automatic drive_sts(input bit mm, input logic v, input logic [7:0] d);
        if (mm) begin ifa.M_AXIS_MM2S_STS_tvalid = v; ifa.M_AXIS_MM2S_STS_tdata = d; end
        else    begin ifa.M_AXIS_S2MM_STS_tvalid = v; ifa.M_AXIS_S2MM_STS_tdata = d; end
    endtask

    // Wait for a command, optionally stall it, accept it, check it against the scoreboard.
    task automatic do_cmd(input bit mm, input int hold, output bit got, output logic [71:0] d0);
        int n = 0;
        got = 0;
        d0  = '0;
        while (!cmd_vld(mm) && n < 40) begin @(negedge clk); n++; end
        if (!cmd_vld(mm)) begin chk("cmd_timeout", 72'(0), 72'(1)); return; end
        d0 = cmd_dat(mm);
        for (int h = 0; h < hold; h++) begin
            if (!mm) drive_sts(1'b0, 1'b1, 8'h8A);   // a status beat here must not be taken
            @(negedge clk);
            chk("hold_tvalid", 72'(cmd_vld(mm)), 72'(1));
            chk("hold_tdata", cmd_dat(mm), d0);
            chk("sts_rdy_in_cmd", 72'(sts_rdy(mm)), 72'(0));
        end
        drive_sts(mm, 1'b0, 8'h00);
        set_cmd_rdy(mm, 1'b1);
        @(negedge clk);
        set_cmd_rdy(mm, 1'b0);
        if (exp_q.size() > 0) chk("cmd_data", d0, exp_q.pop_front());
        else                  chk("cmd_unexpected", d0, 72'hx);
        chk("one_handshake", 72'(cmd_vld(mm)), 72'(0));
        got = 1;
    endtask

    // Return a status beat four cycles after the command.
    task automatic do_sts(input bit mm, input logic [7:0] v, input bit poke);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start_a = (poke && i == 1);
        end
        start_a = 1'b0;
        chk("sts_ready", 72'(sts_rdy(mm)), 72'(1));
        chk("busy_in_sts", 72'(busy_a), 72'(1));
        chk("done_before_last", 72'(done_a), 72'(0));
        drive_sts(mm, 1'b1, v);
        @(negedge clk);
        drive_sts(mm, 1'b0, 8'h00);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] addrs [4] = '{32'h0, 32'h1000, 32'h0, 32'h1000};
        logic [71:0] d;
        bit got, mm, any_vld;
        int ncmd = 0;
        int lo_s = 0;
        int lo_m = 0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(mk_cmd(k < 2 ? 4'hA : 4'h5, addrs[k]));

        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        chk("start_err_clr", 72'(err_a), 72'(0));
        chk("start_errst_clr", 72'(err_status_a), 72'(0));
        chk("start_done_clr", 72'(done_a), 72'(0));
        chk("start_busy", 72'(busy_a), 72'(1));
        chk("tvalid_after_start", 72'(ifa.S_AXIS_S2MM_CMD_tvalid), 72'(1));

        for (int beat = 0; beat < 4; beat++) begin
            mm = (beat >= 2);
            do_cmd(mm, beat == 0 ? v.hold : 0, got, d);
            if (!got) break;
            if (beat == 0) first_cmd = d;
            ncmd++;
            do_sts(mm, beat == v.bad_beat ? v.bad_val : (mm ? 8'h85 : 8'h8A), v.poke && beat == 2);
            if (beat == v.bad_beat) break;
        end

        if (v.exp_err) begin
            chk("err_on_recover", 72'(err_a), 72'(1));
            any_vld = 0;
            for (int c = 0; c < 30; c++) begin
                if (!ifa.m_axis_s2mm_cmdsts_aresetn) lo_s++;
                if (!ifa.m_axis_mm2s_cmdsts_aresetn) lo_m++;
                any_vld |= ifa.S_AXIS_S2MM_CMD_tvalid | ifa.S_AXIS_MM2S_CMD_tvalid |
                           ifa.M_AXIS_S2MM_STS_tready | ifa.M_AXIS_MM2S_STS_tready;
                @(negedge clk);
            end
            chk("s2mm_rst_len", 72'(lo_s), 72'(v.exp_fail_mm ? 0 : 8));
            chk("mm2s_rst_len", 72'(lo_m), 72'(v.exp_fail_mm ? 8 : 0));
            chk("quiet_after_err", 72'(any_vld), 72'(0));
        end
        chk("done", 72'(done_a), 72'(v.exp_done));
        chk("err", 72'(err_a), 72'(v.exp_err));
        chk("err_status", 72'(err_status_a), 72'(v.exp_err_status));
        chk("busy_end", 72'(busy_a), 72'(0));
        chk("cmd_count", 72'(ncmd), 72'(v.exp_cmds));
        if (idx == 0) chk("first_cmd_literal", first_cmd, 72'h0A_0000_0000_0080_1000);
    endtask

    vec_t tbl [6];

    initial begin
        logic [31:0] b_addrs [4] = '{32'hFFFF_F000, 32'h0000_0000, 32'hFFFF_F000, 32'h0000_0000};
        int n;
        tbl[0] = '{5, 1, -1, 8'h00, 1, 0, 8'h00, 0, 4};
        tbl[1] = '{0, 0,  0, 8'h4A, 0, 1, 8'h4A, 0, 1};
        tbl[2] = '{0, 0,  1, 8'h8B, 0, 1, 8'h8B, 0, 2};
        tbl[3] = '{0, 0,  2, 8'h95, 0, 1, 8'h95, 1, 3};
        tbl[4] = '{0, 0,  3, 8'h05, 0, 1, 8'h05, 1, 4};
        tbl[5] = '{0, 0, -1, 8'h00, 1, 0, 8'h00, 0, 4};

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        ifa.S_AXIS_S2MM_CMD_tready = 0; ifa.S_AXIS_MM2S_CMD_tready = 0;
        ifa.M_AXIS_S2MM_STS_tvalid = 0; ifa.M_AXIS_S2MM_STS_tdata = 0;
        ifa.M_AXIS_MM2S_STS_tvalid = 0; ifa.M_AXIS_MM2S_STS_tdata = 0;
        ifb.S_AXIS_S2MM_CMD_tready = 1; ifb.S_AXIS_MM2S_CMD_tready = 1;
        ifb.M_AXIS_S2MM_STS_tvalid = 0; ifb.M_AXIS_S2MM_STS_tdata = 0;
        ifb.M_AXIS_MM2S_STS_tvalid = 0; ifb.M_AXIS_MM2S_STS_tdata = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", 72'({busy_a, done_a, err_a, err_status_a,
                                ifa.m_axis_s2mm_cmdsts_aresetn, ifa.m_axis_mm2s_cmdsts_aresetn,
                                ifa.S_AXIS_S2MM_CMD_tvalid, ifa.S_AXIS_MM2S_CMD_tvalid,
                                ifa.M_AXIS_S2MM_STS_tready, ifa.M_AXIS_MM2S_STS_tready}), 72'(0));
        reset = 1'b0;
        #1 chk("aresetn_low_before_edge", 72'(ifa.m_axis_s2mm_cmdsts_aresetn), 72'(0));
        @(negedge clk);
        chk("aresetn_rise", 72'({ifa.m_axis_s2mm_cmdsts_aresetn, ifa.m_axis_mm2s_cmdsts_aresetn}), 72'(2'b11));

        // Table-driven runs
        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // Address wrap at the top of the address space (second DUT, always-ready DataMover)
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(mk_cmd(k < 2 ? 4'hA : 4'h5, b_addrs[k]));
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int beat = 0; beat < 4; beat++) begin
            n = 0;
            while (!(ifb.S_AXIS_S2MM_CMD_tvalid | ifb.S_AXIS_MM2S_CMD_tvalid) && n < 40) begin
                @(negedge clk); n++;
            end
            if (exp_q.size() > 0)
                chk("wrap_cmd", beat < 2 ? ifb.S_AXIS_S2MM_CMD_tdata : ifb.S_AXIS_MM2S_CMD_tdata,
                    exp_q.pop_front());
            repeat (3) @(negedge clk);
            if (beat < 2) begin ifb.M_AXIS_S2MM_STS_tvalid = 1; ifb.M_AXIS_S2MM_STS_tdata = 8'h8A; end
            else          begin ifb.M_AXIS_MM2S_STS_tvalid = 1; ifb.M_AXIS_MM2S_STS_tdata = 8'h85; end
            @(negedge clk);
            ifb.M_AXIS_S2MM_STS_tvalid = 0; ifb.M_AXIS_MM2S_STS_tvalid = 0;
        end
        chk("wrap_done_no_err", 72'({done_b, err_b, busy_b}), 72'(3'b100));

        // Async reset in the middle of an S2MM command
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        chk("pre_reset_cmd", 72'(ifa.S_AXIS_S2MM_CMD_tvalid), 72'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrun_rst_outputs", 72'({busy_a, done_a, err_a, err_status_a,
                                       ifa.m_axis_s2mm_cmdsts_aresetn, ifa.m_axis_mm2s_cmdsts_aresetn,
                                       ifa.S_AXIS_S2MM_CMD_tvalid, ifa.S_AXIS_MM2S_CMD_tvalid,
                                       ifa.M_AXIS_S2MM_STS_tready, ifa.M_AXIS_MM2S_STS_tready}), 72'(0));
        chk("midrun_rst_tdata", ifa.S_AXIS_S2MM_CMD_tdata, 72'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrun_aresetn_back", 72'({ifa.m_axis_s2mm_cmdsts_aresetn, ifa.m_axis_mm2s_cmdsts_aresetn}), 72'(2'b11));
        chk("midrun_idle", 72'({busy_a, ifa.S_AXIS_S2MM_CMD_tvalid}), 72'(0));

        // Normal run again after the abort
        run_vec(tbl[5], 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ddr_ring_sequencer.md
Name: ddr_ring_sequencer

Overview:
Sequences the AXI DataMover for one capture/readback cycle. It issues NUM_BLOCKS consecutive S2MM write commands that fill a DDR region from the ADC stream. It then issues NUM_BLOCKS MM2S read commands over the same region, and checks each status beat before the next command. It sits between the top-level start/restart logic and the DataMover command/status AXI-Stream ports, and it drives the DataMover cmdsts reset for error recovery.

Parameters:
BTT, 23'h00_1000, bytes per command; must be a nonzero multiple of 8
NUM_BLOCKS, 16, commands per direction per run; range 1..255
BASE_ADDR, 32'h0000_0000, DDR start address of the region
S2MM_TAG, 4'hA, tag placed in S2MM commands and expected in S2MM status
MM2S_TAG, 4'h5, tag placed in MM2S commands and expected in MM2S status
RST_CYCLES, 8, cycles cmdsts_aresetn is held low on error recovery (min 3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled in IDLE, DONE or ERROR
busy  out  1  high from the accepted start until DONE or ERROR
done  out  1  level; high in DONE until the next accepted start
err  out  1  level; high in ERROR/RECOVER/IDLE-after-error until the next accepted start
err_status  out  8  first failing status byte, latched
m_axis_s2mm_cmdsts_aresetn  out  1  DataMover S2MM cmd/status reset, active-low
S_AXIS_S2MM_CMD_tdata  out  72  S2MM command
S_AXIS_S2MM_CMD_tvalid  out  1  S2MM command valid
S_AXIS_S2MM_CMD_tready  in  1  S2MM command ready
M_AXIS_S2MM_STS_tdata  in  8  S2MM status
M_AXIS_S2MM_STS_tvalid  in  1  S2MM status valid
M_AXIS_S2MM_STS_tready  out  1  S2MM status ready
m_axis_mm2s_cmdsts_aresetn, S_AXIS_MM2S_CMD_*, M_AXIS_MM2S_STS_*  same widths and meanings as the S2MM ports, for MM2S

Behaviour:
- Reset values: all outputs 0, err_status 8'h00, state IDLE, block counter 0.
- Both aresetn outputs rise on the first clk edge after reset deasserts.
- Command word: [71:68]=0, [67:64]=tag, [63:32]=address, [31:24]=0, [23]=1 (INCR), [22:0]=BTT.
  - Address of block k = BASE_ADDR + k*BTT, computed modulo 2^32 (wraps, no error).
- States: IDLE, S2MM_CMD, S2MM_STS, MM2S_CMD, MM2S_STS, DONE, RECOVER, ERROR.
- IDLE/DONE/ERROR + start=1 -> S2MM_CMD next cycle:
  - k=0; done and err cleared; busy=1.
  - CMD tvalid is high on the cycle after start is sampled.
- S2MM_CMD: tvalid=1, tdata stable until tvalid&tready, then -> S2MM_STS. No combinational path from tready to tvalid.
- S2MM_STS: STS_tready=1; status is checked on tvalid.
  - Good status = bit7 OKAY=1, bits[6:4]=0, bits[3:0]=S2MM_TAG.
  - Good and k<NUM_BLOCKS-1 -> k+1, S2MM_CMD.
  - Good and last block -> k=0, MM2S_CMD.
  - Bad status -> latch err_status, RECOVER.
- MM2S_CMD / MM2S_STS: same rules using MM2S_TAG.
  - Good and last block -> DONE: done=1, busy=0.
- STS_tready is 0 in all states except the matching *_STS state. At most one command is outstanding per direction.
- RECOVER: the failing direction's aresetn=0 for exactly RST_CYCLES cycles.
  - All tvalid=0 and STS_tready=0.
  - Then -> ERROR: err=1, busy=0.
- err_status holds the first failure only and clears on the next accepted start.
- start while busy is ignored with no effect.
- A status beat in a CMD state is not consumed; tready stays 0.
- Async reset mid-run: immediately force the reset values and abort the run; no partial command completes from this block's side.
- Counter widths: k is 8 bits; address is a 32-bit adder (BASE_ADDR + k*BTT, or accumulated +BTT per block).

Test Plan:
1. NUM_BLOCKS=2, BTT=0x1000, cmd tready=1, status returned 4 cycles after each command with 0x8A/0x85 -> S2MM commands at 0x0 then 0x1000; then MM2S commands at 0x0 then 0x1000. Command tdata = {8'h0A,32'h0,8'h00,1'b1,23'h1000} for the first. done rises after the 4th status; busy falls in the same cycle.
2. Hold S2MM_CMD_tready low for 5 cycles -> tvalid stays 1 and tdata is unchanged every cycle; exactly one handshake occurs when tready rises.
3. Return S2MM status 0x4A on block 0 -> err_status=0x4A; m_axis_s2mm_cmdsts_aresetn low for exactly 8 cycles; MM2S aresetn stays 1; no further commands; err=1, busy=0.
4. Return status 0x8B (tag mismatch) -> same error path; then pulse start -> err clears and the run restarts at BASE_ADDR.
5. BASE_ADDR=0xFFFF_F000, NUM_BLOCKS=2 -> second S2MM address is 0x0000_0000; no error.
6. Pulse start while in MM2S_STS -> ignored. Assert reset mid S2MM_CMD -> all outputs 0 immediately; aresetn returns 1 one cycle after release; state IDLE.
